// File: rtl/ir_regfile_integrated.sv
// ============================================================================
// Module      : ir_regfile_integrated
// Description : Instruction register with field decode and a 16x16 register
//               file, written from a selectable datapath source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_regfile_integrated (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] MD,
  input  logic        IW,
  input  logic        RW,
  input  logic [2:0]  RWSrc,
  input  logic [15:0] ALUO,
  input  logic [15:0] B,
  input  logic [15:0] PC,
  output logic [3:0]  Op,
  output logic [2:0]  CC,
  output logic        LMC,
  output logic [15:0] upper,
  output logic [15:0] signE,
  output logic [15:0] D1,
  output logic [15:0] D2
);

  localparam logic [2:0] C_SRC_ALUO  = 3'b000;
  localparam logic [2:0] C_SRC_MD    = 3'b001;
  localparam logic [2:0] C_SRC_PC    = 3'b010;
  localparam logic [2:0] C_SRC_B     = 3'b011;
  localparam logic [2:0] C_SRC_UPPER = 3'b100;
  localparam logic [2:0] C_SRC_SIGNE = 3'b101;

  logic [15:0] ir_q;
  logic [15:0] ir_d;
  logic [15:0] rf_q [16];
  logic [3:0]  w_rs;
  logic [3:0]  w_rt;
  logic [3:0]  w_rd;
  logic [15:0] w_wd;

  assign Op    = ir_q[15:12];
  assign CC    = ir_q[2:0];
  assign LMC   = ir_q[3];
  assign upper = {ir_q[11:4], 8'h00};
  assign signE = {{8{ir_q[11]}}, ir_q[11:4]};

  assign w_rs = ir_q[11:8];
  assign w_rt = ir_q[7:4];
  assign w_rd = ir_q[11:8];

  // R0 reads as zero regardless of what its storage holds.
  assign D1 = (w_rs == 4'd0) ? 16'h0000 : rf_q[w_rs];
  assign D2 = (w_rt == 4'd0) ? 16'h0000 : rf_q[w_rt];

  always_comb begin
    ir_d = IW ? MD : ir_q;
  end

  always_comb begin
    w_wd = 16'h0000;
    case (RWSrc)
      C_SRC_ALUO:  w_wd = ALUO;
      C_SRC_MD:    w_wd = MD;
      C_SRC_PC:    w_wd = PC;
      C_SRC_B:     w_wd = B;
      C_SRC_UPPER: w_wd = upper;
      C_SRC_SIGNE: w_wd = signE;
      default:     w_wd = 16'h0000;
    endcase
  end

  // The write decodes rd/upper/signE from the pre-edge IR, so IW and RW
  // on the same edge behave as write-then-load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_q <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else begin
      ir_q <= ir_d;
      if (RW && (w_rd != 4'd0)) begin
        rf_q[w_rd] <= w_wd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_regfile_integrated.sv
// ============================================================================
// Module      : tb_ir_regfile_integrated
// Description : Directed self-checking bench for ir_regfile_integrated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_regfile_integrated;

  logic        CLK;
  logic        RST;
  logic [15:0] MD;
  logic        IW;
  logic        RW;
  logic [2:0]  RWSrc;
  logic [15:0] ALUO;
  logic [15:0] B;
  logic [15:0] PC;
  logic [3:0]  Op;
  logic [2:0]  CC;
  logic        LMC;
  logic [15:0] upper;
  logic [15:0] signE;
  logic [15:0] D1;
  logic [15:0] D2;

  int n_tests = 0;
  int n_fail  = 0;

  ir_regfile_integrated dut (
    .CLK   (CLK),
    .RST   (RST),
    .MD    (MD),
    .IW    (IW),
    .RW    (RW),
    .RWSrc (RWSrc),
    .ALUO  (ALUO),
    .B     (B),
    .PC    (PC),
    .Op    (Op),
    .CC    (CC),
    .LMC   (LMC),
    .upper (upper),
    .signE (signE),
    .D1    (D1),
    .D2    (D2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [3:0] op_e, input logic [2:0] cc_e,
                           input logic lmc_e);
    check({tag, ".Op"},  {12'h000, Op},  {12'h000, op_e});
    check({tag, ".CC"},  {13'h0000, CC}, {13'h0000, cc_e});
    check({tag, ".LMC"}, {15'h0000, LMC}, {15'h0000, lmc_e});
  endtask

  initial begin
    RST = 1'b1; MD = 16'h0000; IW = 1'b0; RW = 1'b0; RWSrc = 3'b000;
    ALUO = 16'h0000; B = 16'h0000; PC = 16'h0000;
    #1;
    tick();
    tick();
    RST = 1'b0;
    check_dec("reset", 4'h0, 3'b000, 1'b0);
    check("reset.upper", upper, 16'h0000);
    check("reset.signE", signE, 16'h0000);
    check("reset.D1", D1, 16'h0000);
    check("reset.D2", D2, 16'h0000);

    // Decode checks
    IW = 1'b1; MD = 16'h0127; tick();
    check_dec("ir0127", 4'h0, 3'b111, 1'b0);
    check("ir0127.upper", upper, 16'h1200);
    check("ir0127.signE", signE, 16'h0012);
    MD = 16'h001F; tick();
    check_dec("ir001F", 4'h0, 3'b111, 1'b1);
    check("ir001F.upper", upper, 16'h0100);
    check("ir001F.signE", signE, 16'h0001);
    MD = 16'hE017; tick();
    check_dec("irE017", 4'hE, 3'b111, 1'b0);
    MD = 16'hD017; tick();
    check_dec("irD017", 4'hD, 3'b111, 1'b0);

    // Basic write and hold, with read-during-write visibility
    MD = 16'h0127; tick();
    IW = 1'b0; MD = 16'h5555;
    check("ir_hold.Op", {12'h000, Op}, 16'h0000);
    RW = 1'b1; RWSrc = 3'b000; ALUO = 16'hABCD;
    #1;
    check("rdw.pre_edge", D1, 16'h0000);
    tick();
    check("wr_alu.D1", D1, 16'hABCD);
    check("ir_held.upper", upper, 16'h1200);
    RW = 1'b0; ALUO = 16'h1111; tick();
    check("rw0.hold", D1, 16'hABCD);

    // Write-source sweep on R1
    RW = 1'b1;
    RWSrc = 3'b001; MD = 16'h0127; tick();
    check("src_md", D1, 16'h0127);
    RWSrc = 3'b010; PC = 16'h1234; tick();
    check("src_pc", D1, 16'h1234);
    RWSrc = 3'b011; B = 16'h0021; tick();
    check("src_b", D1, 16'h0021);
    RWSrc = 3'b100; tick();
    check("src_upper", D1, 16'h1200);
    RWSrc = 3'b110; tick();
    check("src_110", D1, 16'h0000);
    RWSrc = 3'b011; tick();
    check("src_b2", D1, 16'h0021);

    // Simultaneous IW and RW: write uses old IR (rd=1, upper=0x1200)
    IW = 1'b1; MD = 16'h0F80; RWSrc = 3'b100; tick();
    check("simul.upper_new", upper, 16'hF800);
    check("simul.signE_new", signE, 16'hFFF8);
    check("simul.R15_untouched", D1, 16'h0000);
    IW = 1'b0; RWSrc = 3'b101; tick();
    check("src_signE", D1, 16'hFFF8);
    check("src_signE.D2", D2, 16'h0000);
    RWSrc = 3'b111; tick();
    check("src_111", D1, 16'h0000);
    RWSrc = 3'b101; tick();
    check("src_signE2", D1, 16'hFFF8);
    RW = 1'b0; IW = 1'b1; MD = 16'h0127; tick();
    check("simul.R1_old_upper", D1, 16'h1200);

    // R0 write discarded
    MD = 16'h0000; tick();
    IW = 1'b0; RW = 1'b1; RWSrc = 3'b000; ALUO = 16'hFFFF; tick();
    check("r0.D1", D1, 16'h0000);
    check("r0.D2", D2, 16'h0000);

    // Reset with IW/RW asserted: reset wins
    RST = 1'b1; IW = 1'b1; MD = 16'hFFFF; tick();
    RST = 1'b0; IW = 1'b0; RW = 1'b0;
    check_dec("rst2", 4'h0, 3'b000, 1'b0);
    check("rst2.upper", upper, 16'h0000);

    IW = 1'b1;
    for (int i = 0; i < 16; i += 2) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(i);
      b = 4'(i + 1);
      MD = {4'h0, a, b, 4'h0};
      tick();
      check($sformatf("rst2.R%0d", i), D1, 16'h0000);
      check($sformatf("rst2.R%0d", i + 1), D2, 16'h0000);
    end
    IW = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
